// File: rtl/gl_square_scanner_if.sv
// Valid/ready stream carrying square descriptors from the scanner to the drawer.
interface gl_square_scanner_if #(
    parameter int IW = 7
);
    logic          sq_valid;
    logic          sq_ready;
    logic [3:0]    sq_x;
    logic [3:0]    sq_y;
    logic [1:0]    sq_color;
    logic [IW-1:0] sq_index;

    modport master (
        output sq_valid, sq_x, sq_y, sq_color, sq_index,
        input  sq_ready
    );

    modport slave (
        input  sq_valid, sq_x, sq_y, sq_color, sq_index,
        output sq_ready
    );
endinterface

// File: rtl/gl_square_scanner.sv
// Walks the gl read port once per next_screen pulse, decodes valid words into
// square descriptors and streams them to the drawer through a small FIFO.
module gl_square_scanner #(
    parameter int DEPTH      = 128,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     next_screen,
    output logic [$clog2(DEPTH)-1:0] address_read_gl,
    input  logic [10:0]              data_read_gl,
    gl_square_scanner_if.master      sq,
    output logic                     busy,
    output logic                     frame_done
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 10 + AW;

    typedef enum logic [2:0] {IDLE, ARM, SCAN, DRAIN, DONE} state_e;

    state_e        state_q;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] infl_addr_q;
    logic          infl_q;
    logic          busy_q;
    logic          done_q;

    logic [EW-1:0] fifo_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    logic          not_empty;
    logic          issue;
    logic          push;
    logic          pop;
    logic [CW:0]   occ;

    // Reserve a FIFO slot for every outstanding read so a push never meets a full FIFO.
    assign occ       = {1'b0, count_q} + {{CW{1'b0}}, infl_q};
    assign issue     = (state_q == SCAN) && (occ < (CW+1)'(FIFO_DEPTH));
    assign not_empty = (count_q != '0);
    assign push      = infl_q && data_read_gl[10];
    assign pop       = not_empty && sq.sq_ready;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            infl_addr_q <= '0;
            infl_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            infl_q <= issue;
            if (issue) begin
                infl_addr_q <= addr_q;
            end
            case (state_q)
                IDLE: begin
                    if (next_screen) begin
                        state_q <= ARM;
                        busy_q  <= 1'b1;
                        addr_q  <= '0;
                    end
                end
                ARM: state_q <= SCAN;
                SCAN: begin
                    if (issue) begin
                        if (addr_q == AW'(DEPTH - 1)) begin
                            state_q <= DRAIN;
                        end else begin
                            addr_q <= addr_q + AW'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (!infl_q && (count_q == '0)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= {data_read_gl[9:6], data_read_gl[5:2],
                                     data_read_gl[1:0], infl_addr_q};
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

    assign address_read_gl = addr_q;
    assign busy            = busy_q;
    assign frame_done      = done_q;
    assign sq.sq_valid     = not_empty;
    // Stale FIFO storage is masked so an empty output always reads as zero.
    assign {sq.sq_x, sq.sq_y, sq.sq_color, sq.sq_index} =
        not_empty ? fifo_q[rd_ptr_q] : '0;
endmodule

// File: tb/tb_gl_square_scanner.sv
// Directed/random frames against a memory model and an address-order descriptor queue.
module tb_gl_square_scanner;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        next_screen = 1'b0;
    logic [6:0]  address_read_gl;
    logic [10:0] data_read_gl = '0;
    logic        busy;
    logic        frame_done;

    gl_square_scanner_if #(.IW(7)) sq_if ();

    gl_square_scanner #(.DEPTH(128), .FIFO_DEPTH(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .next_screen     (next_screen),
        .address_read_gl (address_read_gl),
        .data_read_gl    (data_read_gl),
        .sq              (sq_if),
        .busy            (busy),
        .frame_done      (frame_done)
    );

    always #5 clk = ~clk;

    logic [10:0] mem [128];
    always @(posedge clk) data_read_gl <= mem[address_read_gl];

    int          n_cmp = 0;
    int          n_fail = 0;
    int          fd_count = 0;
    int          xfer_count = 0;
    logic [16:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor: transfers are seen on the negedge preceding the accepting edge.
    logic [16:0] prev_f = '0;
    logic        prev_v = 1'b0;
    logic        prev_r = 1'b0;
    logic        prev_rst = 1'b1;
    always @(negedge clk) begin
        logic [16:0] cur;
        cur = {sq_if.sq_x, sq_if.sq_y, sq_if.sq_color, sq_if.sq_index};
        if (!reset) begin
            if (frame_done) begin
                fd_count++;
                chk("done_after_drain", exp_q.size(), 0);
            end
            if (prev_v && !prev_r && !prev_rst)
                chk("stall_stable", cur, prev_f);
            if (sq_if.sq_valid && sq_if.sq_ready) begin
                xfer_count++;
                chk("xfer_expected", (exp_q.size() > 0) ? 1 : 0, 1);
                if (exp_q.size() > 0) chk("xfer_data", cur, exp_q.pop_front());
            end
        end
        prev_v   = sq_if.sq_valid;
        prev_r   = sq_if.sq_ready;
        prev_rst = reset;
        prev_f   = cur;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_expect();
        exp_q.delete();
        for (int a = 0; a < 128; a++) begin
            if (mem[a][10]) exp_q.push_back({mem[a][9:6], mem[a][5:2], mem[a][1:0], 7'(a)});
        end
    endtask

    task automatic mem_pattern();
        for (int a = 0; a < 128; a++) begin
            logic [6:0] av;
            av = 7'(a);
            mem[a] = {1'b1, av[3:0], av[3:0], av[1:0]};
        end
    endtask

    task automatic start_frame();
        next_screen = 1'b1;
        tick();
        next_screen = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit toggle, input int exp_xfers);
        int start;
        start = fd_count;
        for (int i = 0; i < budget && fd_count == start; i++) begin
            tick();
            if (toggle) sq_if.sq_ready = ~sq_if.sq_ready;
        end
        chk("frame_done_seen", fd_count - start, 1);
        sq_if.sq_ready = 1'b1;
        repeat (6) tick();
        chk("single_done", fd_count - start, 1);
        chk("idle_busy", busy, 0);
        chk("queue_empty", exp_q.size(), 0);
        chk("xfer_total", xfer_count, exp_xfers);
    endtask

    initial begin
        int fd_snap;
        sq_if.sq_ready = 1'b1;
        for (int a = 0; a < 128; a++) mem[a] = '0;

        // Reset state
        reset = 1'b1;
        repeat (3) tick();
        chk("rst_valid", sq_if.sq_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_addr", address_read_gl, 0);
        chk("rst_fields", {sq_if.sq_x, sq_if.sq_y, sq_if.sq_color, sq_if.sq_index}, 0);
        reset = 1'b0;
        tick();

        // All valid, ready high: 2-cycle fill then one descriptor per cycle
        mem_pattern();
        fill_expect();
        xfer_count = 0;
        start_frame();
        chk("arm_busy", busy, 1);
        chk("arm_valid", sq_if.sq_valid, 0);
        tick();
        chk("scan_entry_addr", address_read_gl, 0);
        chk("scan_entry_valid", sq_if.sq_valid, 0);
        tick();
        chk("fill_valid", sq_if.sq_valid, 0);
        tick();
        chk("first_valid", sq_if.sq_valid, 1);
        chk("first_index", sq_if.sq_index, 0);
        for (int k = 1; k < 128; k++) begin
            tick();
            chk("stream_valid", sq_if.sq_valid, 1);
        end
        wait_done(400, 1'b0, 128);

        // Only addresses 5 and 127 valid
        for (int a = 0; a < 128; a++) mem[a] = '0;
        mem[5]   = 11'h7FF;
        mem[127] = 11'h401;
        fill_expect();
        xfer_count = 0;
        start_frame();
        wait_done(400, 1'b0, 2);

        // Stall: 4 entries held, address frozen
        mem_pattern();
        fill_expect();
        xfer_count = 0;
        sq_if.sq_ready = 1'b0;
        start_frame();
        repeat (20) tick();
        chk("stall_valid", sq_if.sq_valid, 1);
        chk("stall_addr", address_read_gl, 4);
        chk("stall_head", sq_if.sq_index, 0);
        repeat (5) tick();
        chk("stall_addr_frozen", address_read_gl, 4);
        sq_if.sq_ready = 1'b1;
        wait_done(600, 1'b0, 128);

        // Random valid bits, ready toggling every cycle
        for (int a = 0; a < 128; a++) mem[a] = 11'($urandom);
        fill_expect();
        xfer_count = 0;
        fd_snap = exp_q.size();
        start_frame();
        wait_done(2000, 1'b1, fd_snap);

        // Second next_screen mid-frame is ignored
        for (int a = 0; a < 128; a++) mem[a] = 11'($urandom);
        fill_expect();
        xfer_count = 0;
        fd_snap = exp_q.size();
        start_frame();
        for (int i = 0; i < 400 && address_read_gl != 7'd60; i++) tick();
        chk("reach_addr60", address_read_gl, 60);
        start_frame();
        chk("busy_after_repulse", busy, 1);
        wait_done(600, 1'b0, fd_snap);
        fill_expect();
        xfer_count = 0;
        start_frame();
        chk("fresh_addr_arm", address_read_gl, 0);
        tick();
        chk("fresh_addr_scan", address_read_gl, 0);
        wait_done(600, 1'b0, fd_snap);

        // Reset mid-frame with entries queued
        mem_pattern();
        fill_expect();
        start_frame();
        for (int i = 0; i < 400 && address_read_gl != 7'd38; i++) tick();
        chk("reach_addr38", address_read_gl, 38);
        sq_if.sq_ready = 1'b0;
        repeat (2) tick();
        chk("queued_valid", sq_if.sq_valid, 1);
        fd_snap = fd_count;
        reset = 1'b1;
        tick();
        chk("mid_rst_valid", sq_if.sq_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_addr", address_read_gl, 0);
        chk("mid_rst_done", frame_done, 0);
        reset = 1'b0;
        exp_q.delete();
        sq_if.sq_ready = 1'b1;
        repeat (10) tick();
        chk("no_done_after_rst", fd_count, fd_snap);
        chk("post_rst_valid", sq_if.sq_valid, 0);
        chk("post_rst_busy", busy, 0);

        // All invalid: full sequence, no descriptors, one frame_done
        for (int a = 0; a < 128; a++) mem[a] = 11'h3FF;
        fill_expect();
        xfer_count = 0;
        start_frame();
        wait_done(600, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/gl_square_scanner.md
Name: gl_square_scanner

Overview:
- Graphics-side consumer of the operational memory's gl read port.
- On each next_screen pulse it walks all 128 words in address order and decodes each 11-bit word into a square descriptor.
- Invalid entries are dropped; valid descriptors are streamed to the square drawer over a valid/ready interface through a 4-entry FIFO.
- frame_done is pulsed once the whole memory has been scanned and the FIFO has drained.

Parameters:
- DEPTH, 128, number of memory words scanned per frame; addresses 0..DEPTH-1.
- FIFO_DEPTH, 4, number of output FIFO entries; must be a power of 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- next_screen  in  1  single-cycle start pulse; the same net drives the memory's next_screen
- address_read_gl  out  7  read address to the memory gl port
- data_read_gl  in  11  memory word, valid 1 cycle after its address is presented
- sq_valid  out  1  descriptor available at the output
- sq_ready  in  1  drawer accepts the descriptor
- sq_x  out  4  column, taken from word[9:6]
- sq_y  out  4  row, taken from word[5:2]
- sq_color  out  2  colour, taken from word[1:0]
- sq_index  out  7  memory address the descriptor came from
- busy  out  1  high in every state except IDLE
- frame_done  out  1  single-cycle pulse at the end of a frame

Behaviour:
Reset:
- State goes to IDLE, FIFO is emptied, address counter is 0.
- address_read_gl=0, sq_valid=0, sq_* fields=0, busy=0, frame_done=0.
- A reset asserted mid-frame aborts the frame immediately. No frame_done is produced and FIFO contents are discarded.

States:
- IDLE: waits for next_screen=1, then goes to ARM.
- ARM: exactly 1 cycle. This lets the memory's gl_reading flag settle.
- SCAN:
  - Issue condition: a read is issued when (FIFO occupancy + in-flight read count) < FIFO_DEPTH.
  - On an issue cycle, address_read_gl = addr and an in-flight flag is set.
  - The data for that read arrives on data_read_gl the next cycle.
  - addr increments on each issue. After the issue of DEPTH-1, addr holds at DEPTH-1 (no wrap) and the state goes to DRAIN.
- DRAIN: waits until the in-flight flag is clear and the FIFO is empty, then goes to DONE.
- DONE: asserts frame_done for 1 cycle, then goes to IDLE.

Return data:
- A word returning while the in-flight flag is set is captured together with its address.
- If word[10]=1, the word is pushed as {x, y, color, index}.
- If word[10]=0, the word is dropped and the FIFO is unchanged. It still frees its in-flight slot.

Pipelining:
- At most 1 read is in flight; issue and capture can overlap.
- With sq_ready held high and all words valid, one read is issued per cycle.
- The first descriptor reaches sq_valid 2 cycles after the SCAN entry cycle: issue at cycle N, capture/push at the N+1 edge, FIFO output visible from cycle N+2.

Output interface:
- sq_valid = FIFO not empty; the sq_* fields show the FIFO head.
- A transfer occurs when sq_valid and sq_ready are both high on a clock edge; the head is popped on that edge.
- While sq_valid=1 and sq_ready=0, all sq_* fields hold stable.

Simultaneous events and boundaries:
- Push and pop in the same cycle leave occupancy unchanged; this is legal even when the FIFO is full.
- The issue rule guarantees a push never arrives while the FIFO is full.
- next_screen asserted in any state other than IDLE is ignored.
- A frame with all words invalid still runs the full sequence: it produces 0 descriptors and one frame_done.
- busy is high from ARM through DONE inclusive.

Test Plan:
- All 128 words valid (word=0x400|addr[3:0]<<6|addr[3:0]<<2|addr[1:0]), sq_ready=1 -> 128 descriptors with sq_index 0..127 in order, one per cycle after a 2-cycle fill; exactly one frame_done.
- Only addresses 5 and 127 valid (0x7FF and 0x401) -> exactly 2 descriptors: (x=15, y=15, c=3, idx=5) then (x=0, y=0, c=1, idx=127). frame_done follows the second accept.
- All words valid, sq_ready=0 for 20 cycles -> exactly 4 entries held with sq_* stable, address frozen, no loss. Releasing sq_ready resumes in order with no duplicates.
- sq_ready toggling every cycle with random valid bits -> output sequence equals the valid words in address order; FIFO never overflows.
- next_screen pulsed again at address 60 -> ignored; a single frame_done; the next next_screen after IDLE starts a fresh scan at address 0.
- reset asserted at address 40 with 3 entries queued -> next cycle sq_valid=0, busy=0, address=0, and no frame_done is produced.
